// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte buffer between the UART serial receiver and the 6809
//   data-bus read mux. Bytes strobed in by the receiver are queued and the
//   oldest one is presented as the UART data register. A completed 6809 read
//   of the data register pops it. A completed read of the status register
//   clears the sticky overrun flag. All 6809 bus inputs are asynchronous and
//   are synchronized here.
//
//   Optional feature macro: UART_RX_FIFO_THRESH_IRQ_EN
//     When it is defined, status bit3 reports count >= THRESH. The interrupt
//     is then raised on threshold, on overrun, or on an idle timeout of 4096
//     clk with data waiting.
//     When it is undefined, status bit3 reads 0 and the interrupt is raised
//     whenever the FIFO is not empty.
//
// Parameters
//   DEPTH   FIFO entries, power of two, 4..16
//   THRESH  fill level for the threshold interrupt, 1..DEPTH
// Ports
//   clk               internal oscillator clock
//   reset             synchronous active-high reset
//   i_rx_data         received byte
//   i_rx_valid        one-cycle strobe qualifying i_rx_data
//   i_uart_data_ce    data register select (async)
//   i_uart_status_ce  status register select (async)
//   i_RW              6809 read/write, 1 = read (async)
//   i_E               6809 E clock (async)
//   o_rx_byte         head-of-FIFO byte, 0x00 when empty
//   o_status          {min(count,15), threshold, full, overrun, not_empty}
//   o_irq_n           interrupt request, active low
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int THRESH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic       i_uart_data_ce,
  input  logic       i_uart_status_ce,
  input  logic       i_RW,
  input  logic       i_E,
  output logic [7:0] o_rx_byte,
  output logic [7:0] o_status,
  output logic       o_irq_n
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 4 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two in 4..16");
  end
  if (THRESH < 1 || THRESH > DEPTH) begin : g_bad_thresh
    $error("uart_rx_fifo: THRESH must be in 1..DEPTH");
  end

  // ---------------------------------------------------------------------
  // Bus synchronizers
  // E gets a third flop for edge detection. The control lines also get a
  // third flop, so that the qualifiers used at the falling edge are the
  // ones sampled together with the last E-high sample. Address lines may
  // already have moved on by the time the falling edge is seen.
  // ---------------------------------------------------------------------
  logic e_meta_reg, e_sync_reg, e_dly_reg;
  logic [2:0] ctl_in;                 // [2]=RW, [1]=data_ce, [0]=status_ce
  logic [2:0] ctl_meta_reg, ctl_sync_reg, ctl_dly_reg;

  assign ctl_in = {i_RW, i_uart_data_ce, i_uart_status_ce};

  always_ff @(posedge clk) begin
    if (reset) begin
      e_meta_reg <= 1'b0;
      e_sync_reg <= 1'b0;
      e_dly_reg  <= 1'b0;
    end else begin
      e_meta_reg <= i_E;
      e_sync_reg <= e_meta_reg;
      e_dly_reg  <= e_sync_reg;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_ctl_sync
    always_ff @(posedge clk) begin
      if (reset) begin
        ctl_meta_reg[gi] <= 1'b0;
        ctl_sync_reg[gi] <= 1'b0;
        ctl_dly_reg[gi]  <= 1'b0;
      end else begin
        ctl_meta_reg[gi] <= ctl_in[gi];
        ctl_sync_reg[gi] <= ctl_meta_reg[gi];
        ctl_dly_reg[gi]  <= ctl_sync_reg[gi];
      end
    end
  end

  logic e_fall, data_rd, status_rd;
  assign e_fall    = e_dly_reg & ~e_sync_reg;
  assign data_rd   = e_fall & ctl_dly_reg[2] & ctl_dly_reg[1];
  assign status_rd = e_fall & ctl_dly_reg[2] & ctl_dly_reg[0];

  // ---------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overrun_reg, overrun_next;
  logic [7:0]       rx_byte_reg, rx_byte_next;
  logic [7:0]       status_reg, status_next;
  logic             irq_n_reg, irq_n_next;

  logic       pop, push, full, overrun_set, thresh_bit;
  logic [7:0] head;
  logic [4:0] cnt_ext;
  logic [3:0] cnt_nib;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= i_rx_data;
    end
  end

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  // Idle timeout: counts clocks since the last push while data is waiting
  // and saturates at its terminal value.
  logic [11:0] idle_cnt_reg;
  logic        idle_timeout;

  assign idle_timeout = (idle_cnt_reg == 12'hFFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_reg <= '0;
    end else if (push || count_reg == '0) begin
      idle_cnt_reg <= '0;
    end else if (!idle_timeout) begin
      idle_cnt_reg <= idle_cnt_reg + 12'd1;
    end
  end
`endif

  always_comb begin
    pop         = data_rd && (count_reg != '0);
    full        = (count_reg == CNT_W'(DEPTH));
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    push        = i_rx_valid && (!full || pop);
    overrun_set = i_rx_valid && full && !pop;

    wr_ptr_next  = wr_ptr_reg + PTR_W'(push);
    rd_ptr_next  = rd_ptr_reg + PTR_W'(pop);
    count_next   = count_reg + CNT_W'(push) - CNT_W'(pop);
    // Set takes priority over a same-cycle clear.
    overrun_next = overrun_set | (overrun_reg & ~status_rd);

    // A byte written into an empty FIFO this cycle is not yet in the array,
    // so it is forwarded directly to the output register.
    if (push && (wr_ptr_reg == rd_ptr_next)) begin
      head = i_rx_data;
    end else begin
      head = mem[rd_ptr_next];
    end
    rx_byte_next = (count_next != '0) ? head : 8'h00;

    cnt_ext = 5'(count_next);
    cnt_nib = (cnt_ext > 5'd15) ? 4'hF : cnt_ext[3:0];

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    thresh_bit = (count_next >= CNT_W'(THRESH));
    irq_n_next = ~((count_reg >= CNT_W'(THRESH)) | overrun_reg | idle_timeout);
`else
    thresh_bit = 1'b0;
    irq_n_next = ~(count_reg != '0);
`endif

    status_next = {cnt_nib, thresh_bit, (count_next == CNT_W'(DEPTH)),
                   overrun_next, (count_next != '0)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
      rx_byte_reg <= 8'h00;
      status_reg  <= 8'h00;
      irq_n_reg   <= 1'b1;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      overrun_reg <= overrun_next;
      rx_byte_reg <= rx_byte_next;
      status_reg  <= status_next;
      irq_n_reg   <= irq_n_next;
    end
  end

  assign o_rx_byte = rx_byte_reg;
  assign o_status  = status_reg;
  assign o_irq_n   = irq_n_reg;

endmodule
